cfg_commit_scheduler: RTL and testbench

//  Buffers configuration register writes decoded from the SPI receiver (colors, misc)
//  in a small FIFO and commits them to the shared config register file only during

---
 rtl/cfg_commit_scheduler_if.sv | 29 ++
 rtl/cfg_commit_scheduler.sv | 136 +++++++++++++
 tb/tb_cfg_commit_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_commit_scheduler_if.sv
// Write-request and commit buses of the config commit scheduler.
//
// Handshake: wr_valid is a single-cycle request carrying wr_addr/wr_data. It is
// taken when wr_ready is high at the same rising edge. The producer cannot
// stall, so a request seen while wr_ready is low is dropped, not held.
// cfg_we is a one-cycle write strobe with cfg_addr/cfg_data; the register file
// has no back-pressure.
interface cfg_commit_scheduler_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 6
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, cfg_we, cfg_addr, cfg_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, cfg_we, cfg_addr, cfg_data
    );
endinterface

// File: rtl/cfg_commit_scheduler.sv
// Buffers config register writes in a small FIFO and commits them to the
// register file only during vertical blanking (or at once when IMMEDIATE=1),
// so a frame never renders with half-applied settings.
module cfg_commit_scheduler #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 6,
    parameter int IMMEDIATE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    cfg_commit_scheduler_if.slave        bus,
    input  logic                         blank_start,
    input  logic                         blank_active,
    input  logic                         overflow_clr,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         overflow,
    output logic                         busy,
    output logic [1:0]                   state_dbg_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q;
    logic [PW-1:0]            rd_ptr_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic                     ovf_q;
    logic                     ovf_d;
    logic                     we_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        data_q;

    logic full;
    logic push;
    logic drop;
    logic drain_en;
    logic pop;

    // Readiness comes from registered occupancy only, so a pop in the same
    // cycle never rescues a write that arrives while full.
    assign full     = (count_q == CW'(DEPTH));
    assign push     = bus.wr_valid && !full;
    assign drop     = bus.wr_valid && full;
    assign drain_en = (IMMEDIATE != 0) || blank_active;
    assign pop      = (state_q == S_DRAIN) && (count_q != '0) && drain_en;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Commit FSM: wait for entries, wait for blanking, drain while the window lasts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (push) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if ((IMMEDIATE != 0) || blank_start) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_d == '0) begin
                    state_d = S_IDLE;
                end else if (!drain_en) begin
                    state_d = S_ARMED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage; pointers alone define validity, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.wr_addr, bus.wr_data};
        end
    end

    // Control state, pointers, flag and the registered commit port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            we_q    <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q         <= rd_ptr_q + PW'(1);
                {addr_q, data_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    assign bus.wr_ready = !full;
    assign bus.cfg_we   = we_q;
    assign bus.cfg_addr = addr_q;
    assign bus.cfg_data = data_q;
    assign pending      = count_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q != S_IDLE);
    assign state_dbg_o  = state_q;
endmodule

// File: tb/tb_cfg_commit_scheduler.sv
// Bench for cfg_commit_scheduler: a per-cycle vector table for the blanking
// commit, overflow and short-window cases, hand-written sequences for
// simultaneous events, reset mid-drain and the IMMEDIATE variant, and a
// commit scoreboard fed from the driven writes.
module tb_cfg_commit_scheduler;
    localparam int AW = 3;
    localparam int DW = 6;
    localparam int W  = AW + DW;

    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] ARM = 2'd1;
    localparam logic [1:0] DRN = 2'd2;

    typedef struct {
        logic          wv;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          bs;
        logic          ba;
        logic          oc;
        logic          e_rdy;
        logic [2:0]    e_pend;
        logic [1:0]    e_st;
        logic          e_ovf;
        logic          e_we;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       blank_start, blank_active, overflow_clr;
    logic [2:0] pending;
    logic       overflow, busy;
    logic [1:0] state_dbg;

    logic       bs_imm, ba_imm, oc_imm;
    logic [2:0] pending_imm;
    logic       overflow_imm, busy_imm;
    logic [1:0] state_imm;

    cfg_commit_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    cfg_commit_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus_imm ();

    cfg_commit_scheduler #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW), .IMMEDIATE(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .blank_start  (blank_start),
        .blank_active (blank_active),
        .overflow_clr (overflow_clr),
        .pending      (pending),
        .overflow     (overflow),
        .busy         (busy),
        .state_dbg_o  (state_dbg)
    );

    cfg_commit_scheduler #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW), .IMMEDIATE(1)) dut_imm (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_imm.slave),
        .blank_start  (bs_imm),
        .blank_active (ba_imm),
        .overflow_clr (oc_imm),
        .pending      (pending_imm),
        .overflow     (overflow_imm),
        .busy         (busy_imm),
        .state_dbg_o  (state_imm)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic prev_rdy;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every commit must match the oldest accepted write.
    always @(negedge clk) begin
        if (bus.cfg_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit: got addr %0d data 0x%0h, expected no commit",
                         bus.cfg_addr, bus.cfg_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({bus.cfg_addr, bus.cfg_data} !== e) begin
                    errors++;
                    $display("FAIL commit_order: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             bus.cfg_addr, bus.cfg_data, e[W-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic vec_t mk(input logic wv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic bs, input logic ba, input logic oc,
                                input logic rdy, input logic [2:0] pend, input logic [1:0] st,
                                input logic ovf, input logic we);
        vec_t v;
        v.wv = wv; v.a = a; v.d = d; v.bs = bs; v.ba = ba; v.oc = oc;
        v.e_rdy = rdy; v.e_pend = pend; v.e_st = st; v.e_ovf = ovf; v.e_we = we;
        return v;
    endfunction

    // One clock: drive at negedge, check the registered result just after the edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.wr_valid = v.wv;
        bus.wr_addr  = v.a;
        bus.wr_data  = v.d;
        blank_start  = v.bs;
        blank_active = v.ba;
        overflow_clr = v.oc;
        if (v.wv && prev_rdy) exp_q.push_back({v.a, v.d});
        @(posedge clk);
        #1;
        chk({tag, "_ready"},   bus.wr_ready, v.e_rdy);
        chk({tag, "_pending"}, pending,      v.e_pend);
        chk({tag, "_state"},   state_dbg,    v.e_st);
        chk({tag, "_busy"},    busy,         (v.e_st != IDL) ? 1 : 0);
        chk({tag, "_ovf"},     overflow,     v.e_ovf);
        chk({tag, "_we"},      bus.cfg_we,   v.e_we);
        prev_rdy = v.e_rdy;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        blank_start = 1'b0; blank_active = 1'b0; overflow_clr = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_pending"}, pending,      0);
        chk({tag, "_state"},   state_dbg,    IDL);
        chk({tag, "_busy"},    busy,         0);
        chk({tag, "_ovf"},     overflow,     0);
        chk({tag, "_ready"},   bus.wr_ready, 1);
        chk({tag, "_we"},      bus.cfg_we,   0);
        chk({tag, "_addr"},    bus.cfg_addr, 0);
        chk({tag, "_data"},    bus.cfg_data, 0);
        chk({tag, "_imm_pending"}, pending_imm, 0);
        chk({tag, "_imm_busy"},    busy_imm,    0);
        @(negedge clk);
        reset = 1'b0;
        prev_rdy = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        logic found;
        logic [AW-1:0] got_a;
        logic [DW-1:0] got_d;

        reset = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        blank_start = 1'b0; blank_active = 1'b0; overflow_clr = 1'b0;
        bus_imm.wr_valid = 1'b0; bus_imm.wr_addr = '0; bus_imm.wr_data = '0;
        bs_imm = 1'b0; ba_imm = 1'b0; oc_imm = 1'b0;
        prev_rdy = 1'b1;

        //                 wv a  d      bs ba oc  rdy pend st   ovf we
        // queue two writes and commit them at blanking
        tbl.push_back(mk(1, 1, 6'h2A, 0, 0, 0,  1, 1, ARM, 0, 0));
        tbl.push_back(mk(1, 3, 6'h15, 0, 0, 0,  1, 2, ARM, 0, 0));
        tbl.push_back(mk(0, 0, 6'h00, 1, 1, 0,  1, 2, DRN, 0, 0));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 1, DRN, 0, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 0, IDL, 0, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 0, IDL, 0, 0));
        tbl.push_back(mk(0, 0, 6'h00, 0, 0, 0,  1, 0, IDL, 0, 0));
        // five writes into a four-entry FIFO, then commit and clear
        tbl.push_back(mk(1, 0, 6'h01, 0, 0, 0,  1, 1, ARM, 0, 0));
        tbl.push_back(mk(1, 2, 6'h02, 0, 0, 0,  1, 2, ARM, 0, 0));
        tbl.push_back(mk(1, 4, 6'h03, 0, 0, 0,  1, 3, ARM, 0, 0));
        tbl.push_back(mk(1, 6, 6'h04, 0, 0, 0,  0, 4, ARM, 0, 0));
        tbl.push_back(mk(1, 5, 6'h3F, 0, 0, 0,  0, 4, ARM, 1, 0));
        tbl.push_back(mk(0, 0, 6'h00, 1, 1, 0,  0, 4, DRN, 1, 0));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 3, DRN, 1, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 2, DRN, 1, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 1, DRN, 1, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 0, IDL, 1, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 0, 1,  1, 0, IDL, 0, 0));
        // blanking window too short for four entries
        tbl.push_back(mk(1, 1, 6'h11, 0, 0, 0,  1, 1, ARM, 0, 0));
        tbl.push_back(mk(1, 2, 6'h12, 0, 0, 0,  1, 2, ARM, 0, 0));
        tbl.push_back(mk(1, 3, 6'h13, 0, 0, 0,  1, 3, ARM, 0, 0));
        tbl.push_back(mk(1, 4, 6'h14, 0, 0, 0,  0, 4, ARM, 0, 0));
        tbl.push_back(mk(0, 0, 6'h00, 1, 1, 0,  0, 4, DRN, 0, 0));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 3, DRN, 0, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 2, DRN, 0, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 0, 0,  1, 2, ARM, 0, 0));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 2, ARM, 0, 0));
        tbl.push_back(mk(0, 0, 6'h00, 1, 1, 0,  1, 2, DRN, 0, 0));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 1, DRN, 0, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0,  1, 0, IDL, 0, 1));
        tbl.push_back(mk(0, 0, 6'h00, 0, 0, 0,  1, 0, IDL, 0, 0));

        do_reset("rst0");

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Push while full during a pop, then a push with one entry left in DRAIN.
        apply(mk(1, 0, 6'h21, 0, 0, 0,  1, 1, ARM, 0, 0), "sim_p0");
        apply(mk(1, 1, 6'h22, 0, 0, 0,  1, 2, ARM, 0, 0), "sim_p1");
        apply(mk(1, 2, 6'h23, 0, 0, 0,  1, 3, ARM, 0, 0), "sim_p2");
        apply(mk(1, 3, 6'h24, 0, 0, 0,  0, 4, ARM, 0, 0), "sim_p3");
        apply(mk(0, 0, 6'h00, 1, 1, 0,  0, 4, DRN, 0, 0), "sim_bs");
        apply(mk(1, 5, 6'h25, 0, 1, 0,  1, 3, DRN, 1, 1), "sim_drop");
        apply(mk(0, 0, 6'h00, 0, 1, 0,  1, 2, DRN, 1, 1), "sim_d1");
        apply(mk(0, 0, 6'h00, 0, 1, 0,  1, 1, DRN, 1, 1), "sim_d2");
        apply(mk(1, 7, 6'h2C, 0, 1, 0,  1, 1, DRN, 1, 1), "sim_pushpop");
        apply(mk(0, 0, 6'h00, 0, 1, 0,  1, 0, IDL, 1, 1), "sim_last");
        apply(mk(0, 0, 6'h00, 0, 0, 1,  1, 0, IDL, 0, 0), "sim_clr");
        chk("sim_sb_empty", exp_q.size(), 0);

        // Reset while the first commit of four is on the output.
        apply(mk(1, 1, 6'h31, 0, 0, 0,  1, 1, ARM, 0, 0), "rmd_p0");
        apply(mk(1, 2, 6'h32, 0, 0, 0,  1, 2, ARM, 0, 0), "rmd_p1");
        apply(mk(1, 3, 6'h33, 0, 0, 0,  1, 3, ARM, 0, 0), "rmd_p2");
        apply(mk(1, 4, 6'h34, 0, 0, 0,  0, 4, ARM, 0, 0), "rmd_p3");
        apply(mk(0, 0, 6'h00, 1, 1, 0,  0, 4, DRN, 0, 0), "rmd_bs");
        apply(mk(0, 0, 6'h00, 0, 1, 0,  1, 3, DRN, 0, 1), "rmd_pop");
        do_reset("rmd_rst");
        chk("rmd_discarded", exp_q.size(), 3);
        exp_q.delete();
        apply(mk(0, 0, 6'h00, 0, 1, 0,  1, 0, IDL, 0, 0), "rmd_after0");
        apply(mk(0, 0, 6'h00, 1, 1, 0,  1, 0, IDL, 0, 0), "rmd_after1");
        apply(mk(0, 0, 6'h00, 0, 1, 0,  1, 0, IDL, 0, 0), "rmd_after2");

        // IMMEDIATE variant: commits without any blanking.
        @(negedge clk);
        bus_imm.wr_valid = 1'b1;
        bus_imm.wr_addr  = 3'd7;
        bus_imm.wr_data  = 6'h1F;
        found = 1'b0;
        got_a = '0;
        got_d = '0;
        for (int i = 1; i <= 3; i++) begin
            if (!found) begin
                @(posedge clk);
                #1;
                bus_imm.wr_valid = 1'b0;
                if (bus_imm.cfg_we) begin
                    found = 1'b1;
                    got_a = bus_imm.cfg_addr;
                    got_d = bus_imm.cfg_data;
                end
            end
        end
        chk("imm_commit_seen", found, 1);
        chk("imm_addr", got_a, 7);
        chk("imm_data", got_d, 'h1F);
        @(posedge clk);
        #1;
        chk("imm_single_we", bus_imm.cfg_we, 0);
        chk("imm_pending",   pending_imm,    0);
        chk("imm_state",     state_imm,      IDL);
        chk("imm_ovf",       overflow_imm,   0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
